snax_gemm_streamer: RTL and testbench

SNAX_GEMM_STREAMER -- requirements
Module: snax_gemm_streamer

---
 rtl/snax_gemm_pkg.sv | 24 ++
 rtl/snax_gemm_stream_port.sv | 62 ++++++
 rtl/snax_gemm_streamer.sv | 159 +++++++++++++++
 tb/tb_snax_gemm_streamer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snax_gemm_pkg.sv
// Shared definitions for the GEMM operand streamer: FSM states and
// per-port half/byte-offset helpers.
package snax_gemm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } gemm_state_e;

  // Lower half of the ports streams operand A, upper half operand B.
  function automatic bit port_is_b(input int unsigned idx, input int unsigned num_ports);
    return idx >= (num_ports / 2);
  endfunction

  // Byte offset of a port inside its operand row.
  function automatic int unsigned port_byte_offset(input int unsigned idx,
                                                   input int unsigned num_ports,
                                                   input int unsigned data_width);
    return (idx % (num_ports / 2)) * (data_width / 8);
  endfunction

endpackage

// File: rtl/snax_gemm_stream_port.sv
// One TCDM stream port: holds the request until granted, then captures
// the first response into its data register.
module snax_gemm_stream_port #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 q_ready_i,
  input  logic                 p_valid_i,
  input  logic [DataWidth-1:0] p_data_i,
  output logic                 q_valid_o,
  output logic [AddrWidth-1:0] q_addr_o,
  output logic                 captured_o,
  output logic                 capture_c,
  output logic [DataWidth-1:0] data_o
);

  logic granted_q;
  logic grant_c;

  assign grant_c   = q_valid_o && q_ready_i;
  // Only a response after a registered grant counts, and only the first one.
  assign capture_c = granted_q && !captured_o && p_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_valid_o  <= 1'b0;
      q_addr_o   <= '0;
      granted_q  <= 1'b0;
      captured_o <= 1'b0;
      data_o     <= '0;
    end else begin
      if (load_i) begin
        q_valid_o <= 1'b1;
        q_addr_o  <= addr_i;
      end else if (grant_c) begin
        q_valid_o <= 1'b0;
      end

      if (clr_i) begin
        granted_q <= 1'b0;
      end else if (grant_c) begin
        granted_q <= 1'b1;
      end

      if (clr_i) begin
        captured_o <= 1'b0;
      end else if (capture_c) begin
        captured_o <= 1'b1;
      end

      if (capture_c) begin
        data_o <= p_data_i;
      end
    end
  end

endmodule

// File: rtl/snax_gemm_streamer.sv
// GEMM operand streamer: fetches one A/B tile per step over NumPorts TCDM
// ports and hands the assembled tile to the consumer.
module snax_gemm_streamer
  import snax_gemm_pkg::*;
#(
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned NumPorts   = 16,
  parameter int unsigned CountWidth = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [AddrWidth-1:0]          cfg_base_a_i,
  input  logic [AddrWidth-1:0]          cfg_base_b_i,
  input  logic [AddrWidth-1:0]          cfg_stride_i,
  input  logic [CountWidth-1:0]         cfg_count_i,
  output logic [NumPorts-1:0]           tcdm_q_valid_o,
  output logic [NumPorts*AddrWidth-1:0] tcdm_q_addr_o,
  input  logic [NumPorts-1:0]           tcdm_q_ready_i,
  input  logic [NumPorts-1:0]           tcdm_p_valid_i,
  input  logic [NumPorts*DataWidth-1:0] tcdm_p_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NumPorts*DataWidth-1:0] out_data_o,
  output logic                          busy_o,
  output logic                          done_o
);

  gemm_state_e state_q, state_d;

  logic [CountWidth-1:0] cnt_q;
  logic [CountWidth-1:0] k_q;
  logic [AddrWidth-1:0]  stride_q;
  logic [AddrWidth-1:0]  tile_a_q;
  logic [AddrWidth-1:0]  tile_b_q;

  logic                  clr_c;
  logic                  load_c;
  logic                  all_cap_c;
  logic                  more_c;
  logic [CountWidth:0]   k_inc_c;
  logic [AddrWidth-1:0]  nxt_a_c;
  logic [AddrWidth-1:0]  nxt_b_c;
  logic [NumPorts-1:0]   captured;
  logic [NumPorts-1:0]   capture_now;

  assign k_inc_c   = {1'b0, k_q} + (CountWidth + 1)'(1);
  assign more_c    = k_inc_c < {1'b0, cnt_q};
  assign all_cap_c = &(captured | capture_now);

  // Row base of the tile about to be fetched: config on start, else next stride step.
  assign nxt_a_c = (state_q == IDLE) ? cfg_base_a_i : tile_a_q + stride_q;
  assign nxt_b_c = (state_q == IDLE) ? cfg_base_b_i : tile_b_q + stride_q;

  always_comb begin
    state_d = state_q;
    clr_c   = 1'b0;
    load_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          clr_c = 1'b1;
          if (cfg_count_i != '0) begin
            state_d = FETCH;
            load_c  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        if (all_cap_c) state_d = OUT;
      end
      OUT: begin
        if (out_ready_i) begin
          clr_c = 1'b1;
          if (more_c) begin
            state_d = FETCH;
            load_c  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cfg_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      out_valid_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ready_o <= (state_d == IDLE);
      busy_o      <= (state_d != IDLE);
      out_valid_o <= (state_d == OUT);
      done_o      <= (state_d == DONE);
    end
  end

  // Latched job config and running tile position.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      k_q      <= '0;
      stride_q <= '0;
      tile_a_q <= '0;
      tile_b_q <= '0;
    end else begin
      if (state_q == IDLE && cfg_valid_i) begin
        cnt_q    <= cfg_count_i;
        stride_q <= cfg_stride_i;
        k_q      <= '0;
      end else if (state_q == OUT && out_ready_i) begin
        k_q <= k_inc_c[CountWidth-1:0];
      end
      if (load_c) begin
        tile_a_q <= nxt_a_c;
        tile_b_q <= nxt_b_c;
      end
    end
  end

  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    localparam int unsigned Off = port_byte_offset(i, NumPorts, DataWidth);
    localparam bit          IsB = port_is_b(i, NumPorts);

    logic [AddrWidth-1:0] addr_c;

    assign addr_c = (IsB ? nxt_b_c : nxt_a_c) + AddrWidth'(Off);

    snax_gemm_stream_port #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth)
    ) u_port (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_c),
      .load_i     (load_c),
      .addr_i     (addr_c),
      .q_ready_i  (tcdm_q_ready_i[i]),
      .p_valid_i  (tcdm_p_valid_i[i]),
      .p_data_i   (tcdm_p_data_i[i*DataWidth +: DataWidth]),
      .q_valid_o  (tcdm_q_valid_o[i]),
      .q_addr_o   (tcdm_q_addr_o[i*AddrWidth +: AddrWidth]),
      .captured_o (captured[i]),
      .capture_c  (capture_now[i]),
      .data_o     (out_data_o[i*DataWidth +: DataWidth])
    );
  end

endmodule

// File: tb/tb_snax_gemm_streamer.sv
// Directed self-checking bench for snax_gemm_streamer.
module tb_snax_gemm_streamer;

  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;
  localparam int unsigned NP = 16;
  localparam int unsigned CW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [AW-1:0]     cfg_base_a = '0;
  logic [AW-1:0]     cfg_base_b = '0;
  logic [AW-1:0]     cfg_stride = '0;
  logic [CW-1:0]     cfg_count = '0;
  logic [NP-1:0]     q_valid;
  logic [NP*AW-1:0]  q_addr;
  logic [NP-1:0]     q_ready = '0;
  logic [NP-1:0]     p_valid = '0;
  logic [NP*DW-1:0]  p_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NP*DW-1:0]  out_data;
  logic              busy;
  logic              done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snax_gemm_streamer #(
    .AddrWidth (AW),
    .DataWidth (DW),
    .NumPorts  (NP),
    .CountWidth(CW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_base_a_i   (cfg_base_a),
    .cfg_base_b_i   (cfg_base_b),
    .cfg_stride_i   (cfg_stride),
    .cfg_count_i    (cfg_count),
    .tcdm_q_valid_o (q_valid),
    .tcdm_q_addr_o  (q_addr),
    .tcdm_q_ready_i (q_ready),
    .tcdm_p_valid_i (p_valid),
    .tcdm_p_data_i  (p_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .busy_o         (busy),
    .done_o         (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response word of port i for tile k: bytes i*8..i*8+7, top byte tagged with k.
  function automatic logic [DW-1:0] pat(input int i, input int k);
    logic [DW-1:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = 8'(i * 8 + j);
    r[63:56] = r[63:56] ^ 8'(k * 16);
    return r;
  endfunction

  function automatic logic [AW-1:0] eaddr(input int i, input int k, input logic [AW-1:0] ba,
                                         input logic [AW-1:0] bb, input logic [AW-1:0] st);
    logic [AW-1:0] base;
    logic [AW-1:0] r;
    base = (i < int'(NP / 2)) ? ba : bb;
    r = base + AW'(k) * st + AW'((i % int'(NP / 2)) * 8);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [AW-1:0] st,
                         input int cnt, input int gd15, input int rd15, input int stall, input bit dup);
    int k = 0;
    int fc = 0;
    int stall_left = 0;
    bit first_out = 1'b1;
    bit fin = 1'b0;
    bit allcap;
    bit hs;
    int seen[NP];
    int rc[NP];
    bit cap[NP];
    logic [NP-1:0]    pend = '0;
    logic [NP-1:0]    gnt;
    logic [NP*AW-1:0] paddr = '0;
    logic [NP*DW-1:0] held = '0;
    for (int i = 0; i < int'(NP); i++) begin seen[i] = 0; rc[i] = -1; cap[i] = 1'b0; end

    cfg_base_a = ba; cfg_base_b = bb; cfg_stride = st; cfg_count = CW'(cnt);
    cfg_valid  = 1'b1;
    chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    tick();
    // A config request while busy must be dropped.
    cfg_base_a = '1; cfg_base_b = '1; cfg_stride = '1; cfg_count = CW'(9);

    for (int t = 0; t < 600 && !fin; t++) begin
      if (done) begin
        chk("tiles_before_done", 64'(k), 64'(cnt));
        chk("q_valid_in_done", 64'(q_valid), 64'd0);
        tick();
        cfg_valid = 1'b0;
        chk("done_one_pulse", 64'(done), 64'd0);
        chk("ready_after_done", 64'(cfg_ready), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        fin = 1'b1;
      end else begin
        for (int i = 0; i < int'(NP); i++) begin
          if (pend[i]) begin
            chk("q_valid_hold", 64'(q_valid[i]), 64'd1);
            chk("q_addr_hold", 64'(q_addr[i*AW +: AW]), 64'(paddr[i*AW +: AW]));
          end
          if (q_valid[i] && seen[i] == 0)
            chk($sformatf("q_addr_p%0d_k%0d", i, k), 64'(q_addr[i*AW +: AW]), 64'(eaddr(i, k, ba, bb, st)));
          q_ready[i] = q_valid[i] && (seen[i] >= ((i == int'(NP) - 1) ? gd15 : 0));
          if (q_valid[i]) seen[i]++;
          p_valid[i] = 1'b0;
          p_data[i*DW +: DW] = '0;
          if (rc[i] == 0) begin
            p_valid[i] = 1'b1;
            p_data[i*DW +: DW] = pat(i, k);
            cap[i] = 1'b1;
          end else if (dup && cap[i]) begin
            p_valid[i] = 1'b1;
            p_data[i*DW +: DW] = 64'hdead_beef_0bad_f00d;
          end
        end
        if (ba == 48'h80 && st == 48'h400 && q_valid[0] && seen[0] == 1) begin
          if (k == 0) begin
            chk("port3_addr_k0", 64'(q_addr[3*AW +: AW]), 64'h98);
            chk("port11_addr_k0", 64'(q_addr[11*AW +: AW]), 64'h298);
          end
          if (k == 2) chk("port0_addr_k2", 64'(q_addr[0 +: AW]), 64'h880);
        end

        out_ready = 1'b1;
        if (out_valid) begin
          if (first_out) begin
            first_out = 1'b0;
            held = out_data;
            stall_left = stall;
            allcap = 1'b1;
            for (int i = 0; i < int'(NP); i++) allcap = allcap && cap[i];
            chk("all_captured_before_out", 64'(allcap), 64'd1);
            if (gd15 == 0 && rd15 == 0) chk("tile_latency", 64'(fc), 64'd2);
            for (int i = 0; i < int'(NP); i++)
              chk($sformatf("out_data_p%0d_k%0d", i, k), out_data[i*DW +: DW], pat(i, k));
          end else begin
            chk("out_data_stable", 64'(out_data == held), 64'd1);
            chk("no_req_in_out", 64'(q_valid), 64'd0);
          end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end

        pend  = q_valid & ~q_ready;
        gnt   = q_valid & q_ready;
        paddr = q_addr;
        hs    = out_valid && out_ready;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < int'(NP); i++) begin
          if (rc[i] == 0) rc[i] = -1;
          else if (rc[i] > 0) rc[i]--;
          if (gnt[i]) rc[i] = (i == int'(NP) - 1) ? rd15 : 0;
        end
        if (hs) begin
          k++;
          fc = 0;
          first_out = 1'b1;
          pend = '0;
          for (int i = 0; i < int'(NP); i++) begin seen[i] = 0; rc[i] = -1; cap[i] = 1'b0; end
        end else begin
          fc++;
        end
      end
    end
    if (!fin) chk("job_timeout", 64'd0, 64'd1);
    chk("tile_handshakes", 64'(k), 64'(cnt));
    q_ready = '0; p_valid = '0; out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
    chk({tag, "_q_valid"}, 64'(q_valid), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_q_addr_zero"}, 64'(q_addr == '0), 64'd1);
    chk({tag, "_out_data_zero"}, 64'(out_data == '0), 64'd1);
  endtask

  initial begin
    tick();
    tick();
    chk_reset_outputs("por");
    rst = 1'b0;
    tick();

    run_job(48'h80, 48'h280, 48'h400, 1, 0, 0, 0, 1'b0);
    run_job(48'h80, 48'h280, 48'h400, 3, 0, 0, 0, 1'b0);
    run_job(48'h80, 48'h280, 48'h400, 1, 4, 1, 0, 1'b0);
    run_job(48'h1000, 48'h2000, 48'h100, 2, 0, 0, 5, 1'b1);
    run_job(48'h80, 48'h280, 48'h400, 0, 0, 0, 0, 1'b0);
    run_job(48'hffff_ffff_fff0, 48'h7fff_ffff_fff8, 48'h10, 2, 0, 0, 0, 1'b0);

    // Reset while only the A half has been granted.
    cfg_base_a = 48'h1000; cfg_base_b = 48'h2000; cfg_stride = 48'h100; cfg_count = CW'(2);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    q_ready = 16'h00ff;
    tick();
    q_ready = '0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    p_valid = 16'h00ff;
    p_data = '1;
    tick();
    p_valid = '0;
    p_data = '0;
    chk("post_rst_idle", 64'(cfg_ready), 64'd1);
    chk("post_rst_no_req", 64'(q_valid), 64'd0);
    chk("post_rst_no_out", 64'(out_valid), 64'd0);
    run_job(48'h80, 48'h280, 48'h400, 1, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
